uart_cmd_host: RTL
==================

Name: uart_cmd_host

Overview:
- Packet-level command engine on the system-clock side of uart_control.
- Consumes received bytes from uart_control's rx FIFO interface (read/readdata/rdempty).
- Decodes fixed 5-byte command frames and performs 8-bit register reads and writes on a simple register bus.
- Sends 4-byte response frames into uart_control's tx FIFO interface (write/writedata/wrfull).

Parameters:
- ADDR_W, 8: register bus address width (frame ADDR byte truncated to ADDR_W LSBs).
- SYNC_RX, 8'hA5: command frame sync byte.
- SYNC_TX, 8'h5A: response frame sync byte.
- TIMEOUT_CYCLES, 2500000: max clk cycles between bytes inside a frame (100 ms at 25 MHz).

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous active-low reset.
- uart_read  out  1  rx FIFO read request; one-cycle pulse.
- uart_readdata  in  8  rx FIFO data; valid on the cycle after uart_read.
- uart_rdempty  in  1  rx FIFO empty.
- uart_write  out  1  tx FIFO write strobe.
- uart_writedata  out  8  tx FIFO data; valid while uart_write is high.
- uart_wrfull  in  1  tx FIFO full.
- reg_wr  out  1  register write strobe; one cycle.
- reg_rd  out  1  register read strobe; one cycle.
- reg_addr  out  ADDR_W  register address.
- reg_wdata  out  8  register write data.
- reg_rdata  in  8  register read data; valid the cycle after reg_rd.
- busy  out  1  high whenever state != IDLE.
- err_count  out  8  saturating count of framing, checksum and timeout errors.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-frame or mid-response abandons it; no partial bytes resume.
- Command frame: SYNC_RX, CMD, ADDR, DATA, CSUM, where CSUM = CMD^ADDR^DATA.
- CMD codes: 8'h01 write, 8'h02 read; anything else is unknown.
- Response frame: SYNC_TX, STATUS, RDATA, RCSUM, where RCSUM = STATUS^RDATA.
- STATUS codes: 8'h00 ok, 8'h01 bad checksum, 8'h02 unknown command.
- Byte fetch:
  - uart_read pulses only when !uart_rdempty, no fetch is pending, and the state is a receive state.
  - The byte is captured the following cycle; the next read may issue that same capture cycle.
  - uart_read is never asserted while uart_rdempty is high.
- States: IDLE → CMD → ADDR → DATA → CSUM → EXEC → LATCH → RESP → IDLE.
- IDLE: each fetched byte is compared with SYNC_RX; non-matching bytes are silently discarded and do not count as errors.
- CSUM check after capture:
  - Mismatch → STATUS 01, RDATA 00, no register strobe, err_count++.
  - Unknown CMD with good CSUM → STATUS 02, RDATA 00, no strobe.
- EXEC (cycle N+1 after the CSUM capture at cycle N):
  - Write: reg_wr=1, reg_addr=ADDR, reg_wdata=DATA; RDATA echoes DATA.
  - Read: reg_rd=1, reg_addr=ADDR.
- LATCH (N+2): reg_rdata is sampled into RDATA for reads.
- RESP: first uart_write at N+3 at the earliest.
  - Each byte is written on the first cycle with !uart_wrfull.
  - uart_write is never asserted while uart_wrfull is high.
  - Bytes go out in order; no rx fetches occur during RESP, so incoming bytes remain in the FIFO.
- Timeout (CMD..CSUM only):
  - The counter clears on every captured byte and increments otherwise.
  - Reaching TIMEOUT_CYCLES → IDLE, no response, err_count++.
  - IDLE, EXEC, LATCH and RESP never time out.
- err_count saturates at 8'hFF.
- reg_addr and reg_wdata hold their last values between strobes.

Decomposition:
- Package uart_cmd_pkg holds:
  - CMD_WRITE and CMD_READ.
  - STATUS_OK, STATUS_BADCSUM and STATUS_BADCMD.
  - The state enumeration.
  - Frame length constants (5 and 4).
- Sub-module uart_rsp_ser is the natural split: a 4-byte response serializer.
  - Inputs: start pulse, STATUS, RDATA.
  - Drives uart_write and uart_writedata against uart_wrfull, then asserts done.
  - Computes RCSUM internally.

Test Plan:
- Write frame A5 01 10 3C 2D with an always-non-empty FIFO → reg_wr for 1 cycle, addr 10, wdata 3C; tx bytes 5A 00 3C 3C; err_count 0.
- Read frame A5 02 07 00 05, reg_rdata=9E → reg_rd for 1 cycle, addr 07; tx bytes 5A 00 9E 9E.
- Bad checksum A5 01 10 3C FF → no reg_wr; tx bytes 5A 01 00 01; err_count 1.
- Unknown command A5 07 00 00 07 → tx bytes 5A 02 00 02; no strobes.
- Garbage FF 00 before a valid read frame → garbage discarded, normal response; uart_wrfull held high 20 cycles mid-response → no write while full, byte order preserved.
- Timeout: A5 01 then rdempty held high for TIMEOUT_CYCLES (bench override 100) → IDLE, err_count++, no tx. A following complete frame is serviced normally. A reset_n pulse mid-RESP → outputs 0, no further writes.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command host.
// Holds command/status codes, frame lengths, FSM state encodings and the
// response payload struct handed from the command engine to the serializer.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_BADCSUM = 8'h01;
  localparam logic [7:0] STATUS_BADCMD  = 8'h02;

  localparam int unsigned CMD_FRAME_LEN = 5;
  localparam int unsigned RSP_FRAME_LEN = 4;

  // Receive states are encoded 0..4 so "receive state" is a single compare.
  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_CMD   = 3'd1;
  localparam logic [ST_W-1:0] ST_ADDR  = 3'd2;
  localparam logic [ST_W-1:0] ST_DATA  = 3'd3;
  localparam logic [ST_W-1:0] ST_CSUM  = 3'd4;
  localparam logic [ST_W-1:0] ST_EXEC  = 3'd5;
  localparam logic [ST_W-1:0] ST_LATCH = 3'd6;
  localparam logic [ST_W-1:0] ST_RESP  = 3'd7;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] rdata;
  } rsp_t;

  function automatic logic [7:0] xor3(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return a ^ b ^ c;
  endfunction

endpackage

// File: rtl/uart_cmd_host_ser.sv
// Response frame serializer: SYNC_TX, STATUS, RDATA, STATUS^RDATA.
// Ports: start (load payload), rsp (status/rdata), uart_wrfull (tx FIFO full),
// uart_write/uart_writedata (tx FIFO write side), done (one-cycle pulse after
// the last byte has been written).
module uart_rsp_ser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_TX = 8'h5A
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  rsp_t       rsp,
  input  logic       uart_wrfull,
  output logic       uart_write,
  output logic [7:0] uart_writedata,
  output logic       done
);

  localparam logic [1:0] LAST_IDX = 2'(RSP_FRAME_LEN - 1);

  logic       active;
  logic [1:0] idx;
  logic [7:0] status_q;
  logic [7:0] rdata_q;
  logic [7:0] cur_byte;

  // Byte selected by the current index; checksum is formed on the fly.
  always_comb begin
    cur_byte = SYNC_TX;
    case (idx)
      2'd0:    cur_byte = SYNC_TX;
      2'd1:    cur_byte = status_q;
      2'd2:    cur_byte = rdata_q;
      default: cur_byte = status_q ^ rdata_q;
    endcase
  end

  // Write is gated directly by full so a byte never lands on a full FIFO.
  assign uart_write     = active && !uart_wrfull;
  assign uart_writedata = active ? cur_byte : 8'h00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active   <= 1'b0;
      idx      <= 2'd0;
      status_q <= 8'h00;
      rdata_q  <= 8'h00;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !active) begin
        active   <= 1'b1;
        idx      <= 2'd0;
        status_q <= rsp.status;
        rdata_q  <= rsp.rdata;
      end else if (uart_write) begin
        if (idx == LAST_IDX) begin
          active <= 1'b0;
          done   <= 1'b1;
        end else begin
          idx <= idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_cmd_host.sv
// Packet-level command engine between uart_control FIFOs and a register bus.
// Ports: uart_read/uart_readdata/uart_rdempty (rx FIFO), uart_write/
// uart_writedata/uart_wrfull (tx FIFO), reg_wr/reg_rd/reg_addr/reg_wdata/
// reg_rdata (register bus), busy (not idle), err_count (saturating errors).
module uart_cmd_host
  import uart_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter logic [7:0]  SYNC_RX        = 8'hA5,
  parameter logic [7:0]  SYNC_TX        = 8'h5A,
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              uart_read,
  input  logic [7:0]        uart_readdata,
  input  logic              uart_rdempty,
  output logic              uart_write,
  output logic [7:0]        uart_writedata,
  input  logic              uart_wrfull,
  output logic              reg_wr,
  output logic              reg_rd,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_nx;

  logic          armed;
  logic          cap;
  logic [TW-1:0] tcnt;
  logic [7:0]    cmd_q;
  logic [7:0]    addr_q;
  logic [7:0]    data_q;
  logic [7:0]    status_q;
  logic [7:0]    rdata_q;
  logic          do_read;
  logic          rx_state;
  logic          in_frame;
  logic          csum_cap;
  logic          csum_bad;
  logic          cmd_known;
  logic          tmo_hit;
  logic          ser_start;
  logic          ser_done;
  rsp_t          rsp;

  assign rx_state  = (state <= ST_CSUM);
  assign in_frame  = (state >= ST_CMD) && (state <= ST_CSUM);
  assign csum_cap  = cap && (state == ST_CSUM);
  assign csum_bad  = uart_readdata != xor3(cmd_q, addr_q, data_q);
  assign cmd_known = (cmd_q == CMD_WRITE) || (cmd_q == CMD_READ);
  assign tmo_hit   = in_frame && !cap && (tcnt == TMO_LAST);

  // Read request follows rdempty directly so it is never raised on an empty
  // FIFO; it is held off while the final CSUM byte is being captured so that
  // no byte of the next frame is pulled during EXEC/LATCH/RESP.
  assign uart_read = armed && rx_state && !uart_rdempty &&
                     !(cap && (state == ST_CSUM));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (cap && (uart_readdata == SYNC_RX)) state_nx = ST_CMD;
      ST_CMD:   if (cap) state_nx = ST_ADDR; else if (tmo_hit) state_nx = ST_IDLE;
      ST_ADDR:  if (cap) state_nx = ST_DATA; else if (tmo_hit) state_nx = ST_IDLE;
      ST_DATA:  if (cap) state_nx = ST_CSUM; else if (tmo_hit) state_nx = ST_IDLE;
      ST_CSUM:  if (cap) state_nx = ST_EXEC; else if (tmo_hit) state_nx = ST_IDLE;
      ST_EXEC:  state_nx = ST_LATCH;
      ST_LATCH: state_nx = ST_RESP;
      ST_RESP:  if (ser_done) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Frame capture, register bus strobes, timeout and error bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed     <= 1'b0;
      cap       <= 1'b0;
      tcnt      <= '0;
      cmd_q     <= 8'h00;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      status_q  <= 8'h00;
      rdata_q   <= 8'h00;
      do_read   <= 1'b0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= 8'h00;
      busy      <= 1'b0;
      err_count <= 8'h00;
    end else begin
      armed  <= 1'b1;
      cap    <= uart_read;
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      busy   <= (state_nx != ST_IDLE);

      if (in_frame && !cap && !tmo_hit) tcnt <= tcnt + TW'(1);
      else                              tcnt <= '0;

      if (cap) begin
        case (state)
          ST_CMD:  cmd_q  <= uart_readdata;
          ST_ADDR: addr_q <= uart_readdata;
          ST_DATA: data_q <= uart_readdata;
          default: ;
        endcase
      end

      // Decide the outcome on the CSUM byte; strobes land in EXEC.
      if (csum_cap) begin
        do_read <= 1'b0;
        rdata_q <= 8'h00;
        if (csum_bad) begin
          status_q <= STATUS_BADCSUM;
        end else if (!cmd_known) begin
          status_q <= STATUS_BADCMD;
        end else begin
          status_q <= STATUS_OK;
          reg_addr <= ADDR_W'(addr_q);
          if (cmd_q == CMD_WRITE) begin
            reg_wr    <= 1'b1;
            reg_wdata <= data_q;
            rdata_q   <= data_q;
          end else begin
            reg_rd  <= 1'b1;
            do_read <= 1'b1;
          end
        end
      end

      if (state == ST_LATCH && do_read) rdata_q <= reg_rdata;

      if (((csum_cap && csum_bad) || tmo_hit) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

  // Read data is taken straight from the bus in LATCH so the response can
  // start on the following cycle.
  assign ser_start    = (state == ST_LATCH);
  assign rsp.status   = status_q;
  assign rsp.rdata    = do_read ? reg_rdata : rdata_q;

  uart_rsp_ser #(
    .SYNC_TX (SYNC_TX)
  ) u_ser (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (ser_start),
    .rsp            (rsp),
    .uart_wrfull    (uart_wrfull),
    .uart_write     (uart_write),
    .uart_writedata (uart_writedata),
    .done           (ser_done)
  );

endmodule
